// File: rtl/vehicle_safety_pkg.sv
// Shared types for the vehicle safety sequencer: FSM state encoding and a
// counter-width helper.
package vehicle_safety_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 3'd0,
    DRIVING    = 3'd1,
    OUT_OF_GAS = 3'd2,
    HALTED     = 3'd3,
    ARRIVED    = 3'd4
  } state_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vehicle_safety_sequencer_overheat_filter.sv
// Overheat filter: debounces cpu_overheated into a shut request and holds it
// until the sensor has stayed low for the cooldown period.
module overheat_filter
  import vehicle_safety_pkg::*;
#(
  parameter int OVH_DEBOUNCE = 4,
  parameter int COOLDOWN     = 16
) (
  input  logic clk,
  input  logic areset,
  input  logic cpu_overheated,
  output logic shut,
  output logic shut_rise
);

  localparam int MAX_RUN = (OVH_DEBOUNCE > COOLDOWN) ? OVH_DEBOUNCE : COOLDOWN;
  localparam int CNT_W   = cnt_width(MAX_RUN);

  // One run counter serves both phases: high samples while running,
  // low samples while shut.
  logic [CNT_W-1:0] run_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      shut      <= 1'b0;
      shut_rise <= 1'b0;
      run_cnt   <= '0;
    end else begin
      shut_rise <= 1'b0;
      if (!shut) begin
        if (!cpu_overheated) begin
          run_cnt <= '0;
        end else if (run_cnt == CNT_W'(OVH_DEBOUNCE - 1)) begin
          shut      <= 1'b1;
          shut_rise <= 1'b1;
          run_cnt   <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end else begin
        if (cpu_overheated) begin
          run_cnt <= '0;
        end else if (run_cnt == CNT_W'(COOLDOWN - 1)) begin
          shut    <= 1'b0;
          run_cnt <= '0;
        end else begin
          run_cnt <= run_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vehicle_safety_sequencer.sv
// Trip sequencer: overheat filter, trip FSM and overheat event counter.
// Optional trip watchdog is built when SAFETY_SEQ_WATCHDOG_EN is defined.
module vehicle_safety_sequencer
  import vehicle_safety_pkg::*;
#(
  parameter int OVH_DEBOUNCE = 4,
  parameter int COOLDOWN     = 16,
  parameter int EVT_W        = 8,
  parameter int TRIP_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             cpu_overheated,
  input  logic             arrived,
  input  logic             gas_tank_empty,
  input  logic             trip_start,
  input  logic             refuel_done,
  output logic             shut_off_computer,
  output logic             keep_driving,
  output logic [2:0]       state_o,
  output logic [EVT_W-1:0] overheat_events,
  output logic             timeout_o
);

  state_t state, state_nxt;
  logic   shut, shut_rise;
  logic   base_accept, trip_accept, tmo_hit;

  overheat_filter #(
    .OVH_DEBOUNCE (OVH_DEBOUNCE),
    .COOLDOWN     (COOLDOWN)
  ) u_filter (
    .clk            (clk),
    .areset         (areset),
    .cpu_overheated (cpu_overheated),
    .shut           (shut),
    .shut_rise      (shut_rise)
  );

  assign shut_off_computer = shut;
  assign state_o           = state;
  assign base_accept = (state == IDLE) && trip_start && !shut && !arrived && !gas_tank_empty;

`ifdef SAFETY_SEQ_WATCHDOG_EN
  localparam int TMO_W = cnt_width(TRIP_TIMEOUT);
  logic [TMO_W-1:0] trip_cnt;

  // Counts cumulative DRIVING cycles of the current trip; only a new trip clears it.
  assign trip_accept = base_accept && !timeout_o;
  assign tmo_hit     = (state == DRIVING) && (trip_cnt == TMO_W'(TRIP_TIMEOUT - 1));

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      trip_cnt  <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (trip_accept)           trip_cnt <= '0;
      else if (state == DRIVING) trip_cnt <= trip_cnt + 1'b1;
      if (tmo_hit)               timeout_o <= 1'b1;
    end
  end
`else
  assign trip_accept = base_accept;
  assign tmo_hit     = 1'b0;
  // Watchdog not built: constant 0, expressed through the parameter so it is referenced.
  assign timeout_o   = (TRIP_TIMEOUT < 0);
`endif

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      IDLE:       if (trip_accept) state_nxt = DRIVING;
      DRIVING: begin
        if (shut)                state_nxt = HALTED;
        else if (arrived)        state_nxt = ARRIVED;
        else if (gas_tank_empty) state_nxt = OUT_OF_GAS;
      end
      OUT_OF_GAS: begin
        if (shut)                                state_nxt = HALTED;
        else if (arrived)                        state_nxt = ARRIVED;
        else if (refuel_done && !gas_tank_empty) state_nxt = DRIVING;
      end
      HALTED: begin
        if (!shut) begin
          if (arrived)             state_nxt = ARRIVED;
          else if (gas_tank_empty) state_nxt = OUT_OF_GAS;
          else                     state_nxt = DRIVING;
        end
      end
      ARRIVED:    if (!arrived) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (tmo_hit) state_nxt = IDLE;
  end

  // keep_driving decodes the next state so it changes on the same edge as the FSM.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state           <= IDLE;
      keep_driving    <= 1'b0;
      overheat_events <= '0;
    end else begin
      state        <= state_nxt;
      keep_driving <= (state_nxt == DRIVING);
      if (shut_rise && (overheat_events != '1))
        overheat_events <= overheat_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_vehicle_safety_sequencer.sv
// Self-checking bench for vehicle_safety_sequencer: directed scenarios plus
// randomized stimulus against a cycle-level reference model.
module tb_vehicle_safety_sequencer;

`ifdef SAFETY_SEQ_WATCHDOG_EN
  localparam int TT = 32;
`else
  localparam int TT = 1024;
`endif
  localparam int OVH = 4;
  localparam int COOL = 16;
  localparam int EVT_MAX = 255;

  logic clk = 1'b0;
  logic areset = 1'b0;
  logic cpu_overheated = 1'b0, arrived = 1'b0, gas_tank_empty = 1'b0;
  logic trip_start = 1'b0, refuel_done = 1'b0;
  logic shut_off_computer, keep_driving, timeout_o;
  logic [2:0] state_o;
  logic [7:0] overheat_events;

  int checks = 0;
  int failures = 0;

  // Reference model state (plain integers, states numbered as in the encoding table)
  int  m_state, m_streak, m_events, m_trip_cnt;
  bit  m_shut, m_rise, m_tmo;

  vehicle_safety_sequencer #(
    .OVH_DEBOUNCE (OVH),
    .COOLDOWN     (COOL),
    .EVT_W        (8),
    .TRIP_TIMEOUT (TT)
  ) dut (
    .clk               (clk),
    .areset            (areset),
    .cpu_overheated    (cpu_overheated),
    .arrived           (arrived),
    .gas_tank_empty    (gas_tank_empty),
    .trip_start        (trip_start),
    .refuel_done       (refuel_done),
    .shut_off_computer (shut_off_computer),
    .keep_driving      (keep_driving),
    .state_o           (state_o),
    .overheat_events   (overheat_events),
    .timeout_o         (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_streak = 0; m_events = 0; m_trip_cnt = 0;
    m_shut = 1'b0; m_rise = 1'b0; m_tmo = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs presented before it.
  task automatic model_step();
    bit sh;
    bit accept;
    int ns;
    sh = m_shut;
    ns = m_state;
    if (!sh) begin
      m_streak = cpu_overheated ? m_streak + 1 : 0;
      if (m_streak == OVH) begin m_shut = 1'b1; m_streak = 0; end
    end else begin
      m_streak = !cpu_overheated ? m_streak + 1 : 0;
      if (m_streak == COOL) begin m_shut = 1'b0; m_streak = 0; end
    end
    if (m_rise && m_events < EVT_MAX) m_events++;
    m_rise = m_shut && !sh;

    accept = (m_state == 0) && trip_start && !sh && !arrived && !gas_tank_empty && !m_tmo;
    case (m_state)
      0: if (accept) ns = 1;
      1: ns = sh ? 3 : arrived ? 4 : gas_tank_empty ? 2 : 1;
      2: ns = sh ? 3 : arrived ? 4 : (refuel_done && !gas_tank_empty) ? 1 : 2;
      3: if (!sh) ns = arrived ? 4 : gas_tank_empty ? 2 : 1;
      4: if (!arrived) ns = 0;
      default: ns = 0;
    endcase
`ifdef SAFETY_SEQ_WATCHDOG_EN
    if (accept) m_trip_cnt = 0;
    else if (m_state == 1) begin
      m_trip_cnt++;
      if (m_trip_cnt == TT) begin ns = 0; m_tmo = 1'b1; end
    end
`endif
    m_state = ns;
  endtask

  task automatic compare_all();
    check("state", 32'(state_o), 32'(m_state));
    check("keep_driving", 32'(keep_driving), 32'(m_state == 1));
    check("shut", 32'(shut_off_computer), 32'(m_shut));
    check("events", 32'(overheat_events), 32'(m_events));
    check("timeout", 32'(timeout_o), 32'(m_tmo));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic apply_reset();
    @(negedge clk);
    #2 areset = 1'b1;
    #1;
    check("rst_state", 32'(state_o), 0);
    check("rst_shut", 32'(shut_off_computer), 0);
    check("rst_keep", 32'(keep_driving), 0);
    check("rst_events", 32'(overheat_events), 0);
    check("rst_timeout", 32'(timeout_o), 0);
    model_reset();
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic start_trip();
    trip_start = 1'b1;
    cycle();
    trip_start = 1'b0;
  endtask

  initial begin
    int ovh_left;
    model_reset();
    apply_reset();

    // 1: trip from reset
    start_trip();
    check("t1_state", 32'(state_o), 1);
    check("t1_keep", 32'(keep_driving), 1);

    // 2: overheat shorter than the debounce window
    cpu_overheated = 1'b1; cycles(3);
    cpu_overheated = 1'b0; cycles(2);
    check("t2_shut", 32'(shut_off_computer), 0);
    check("t2_state", 32'(state_o), 1);

    // 3: debounced overheat halts, cooldown resumes driving
    cpu_overheated = 1'b1; cycles(4);
    check("t3_shut_on", 32'(shut_off_computer), 1);
    cpu_overheated = 1'b0; cycle();
    check("t3_halted", 32'(state_o), 3);
    check("t3_keep", 32'(keep_driving), 0);
    check("t3_events", 32'(overheat_events), 1);
    cycles(14);
    check("t3_shut_hold", 32'(shut_off_computer), 1);
    cycle();
    check("t3_shut_off", 32'(shut_off_computer), 0);
    cycle();
    check("t3_resume", 32'(state_o), 1);

    // 4: out of gas, refuel, arrive, return to idle
    gas_tank_empty = 1'b1; cycle();
    check("t4_oog", 32'(state_o), 2);
    gas_tank_empty = 1'b0; refuel_done = 1'b1; cycle();
    refuel_done = 1'b0;
    check("t4_refuel", 32'(state_o), 1);
    arrived = 1'b1; cycle();
    check("t4_arrived", 32'(state_o), 4);
    trip_start = 1'b1; cycle(); trip_start = 1'b0;
    check("t4_ignore_start", 32'(state_o), 4);
    arrived = 1'b0; cycle();
    check("t4_idle", 32'(state_o), 0);

    // 5: arrival coinciding with debounced shut resolves to HALTED
    start_trip();
    cpu_overheated = 1'b1; cycles(4);
    cpu_overheated = 1'b0; arrived = 1'b1; cycle();
    check("t5_halted", 32'(state_o), 3);
    cycles(16);
    check("t5_arrived", 32'(state_o), 4);
    arrived = 1'b0; cycle();

    // trip_start refused while a flag is up
    gas_tank_empty = 1'b1; trip_start = 1'b1; cycle();
    trip_start = 1'b0; gas_tank_empty = 1'b0;
    check("drop_start", 32'(state_o), 0);

    // Reset in the middle of a trip
    start_trip();
    cycles(3);
    check("mid_trip", 32'(state_o), 1);
    apply_reset();

`ifdef SAFETY_SEQ_WATCHDOG_EN
    // 6: watchdog expiry after TT driving cycles, then sticky
    start_trip();
    cycles(TT - 1);
    check("t6_before", 32'(state_o), 1);
    cycle();
    check("t6_idle", 32'(state_o), 0);
    check("t6_timeout", 32'(timeout_o), 1);
    start_trip();
    check("t6_sticky", 32'(state_o), 0);
    apply_reset();
`endif

    // Event counter saturation
    for (int i = 0; i < EVT_MAX + 5; i++) begin
      cpu_overheated = 1'b1; cycles(OVH);
      cpu_overheated = 1'b0; cycles(COOL);
    end
    cycle();
    check("evt_sat", 32'(overheat_events), EVT_MAX);
    apply_reset();

    // Randomized traffic with bursty overheat and occasional resets
    ovh_left = 0;
    for (int n = 0; n < 4000; n++) begin
      if (ovh_left == 0) begin
        cpu_overheated = 1'($urandom_range(0, 1));
        ovh_left = cpu_overheated ? $urandom_range(1, 8) : $urandom_range(1, 30);
      end
      ovh_left--;
      if ($urandom_range(0, 39) == 0) arrived = ~arrived;
      if ($urandom_range(0, 24) == 0) gas_tank_empty = ~gas_tank_empty;
      trip_start  = ($urandom_range(0, 3) == 0);
      refuel_done = ($urandom_range(0, 3) == 0);
      cycle();
      if (n % 1300 == 1299) apply_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
